// File: rtl/hack_ram_arbiter_if.sv
// One requester's channel into hack_ram_arbiter: request/address/data in, grant and
// one-cycle-late read return out.
interface hack_ram_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/hack_ram_arbiter.sv
// Round-robin arbiter with a burst limit sharing the single-port data RAM between
// requester A (core data port) and requester B (secondary master).
module hack_ram_arbiter #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                xrst,
   hack_ram_arbiter_if.slave   a,
   hack_ram_arbiter_if.slave   b,
   output logic                ram_write_en,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_in_data,
   input  logic [DATA_W-1:0]   ram_out_data
);

   typedef enum logic {
      OwnA = 1'b0,
      OwnB = 1'b1
   } owner_e;

   localparam logic [3:0] BurstMax = 4'(MAX_BURST);

   owner_e            last_owner_q, last_owner_d;
   logic [3:0]        burst_cnt_q, burst_cnt_d;
   logic              rd_pend_q, rd_pend_d;
   owner_e            rd_owner_q, rd_owner_d;
   logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

   logic              gnt_a, gnt_b;
   owner_e            winner;
   owner_e            gnt_owner;
   logic              a_rvalid, b_rvalid;

   // Grant decision: only contention consults last_owner / burst_cnt.
   always_comb begin
      gnt_a  = 1'b0;
      gnt_b  = 1'b0;
      winner = OwnA;
      unique case ({a.req, b.req})
         2'b10: gnt_a = 1'b1;
         2'b01: gnt_b = 1'b1;
         2'b11: begin
            if (burst_cnt_q == 4'd0) begin
               winner = (last_owner_q == OwnA) ? OwnB : OwnA;
            end else if (burst_cnt_q < BurstMax) begin
               winner = last_owner_q;
            end else begin
               winner = (last_owner_q == OwnA) ? OwnB : OwnA;
            end
            gnt_a = (winner == OwnA);
            gnt_b = (winner == OwnB);
         end
         default: ;
      endcase
   end

   always_comb begin
      gnt_owner    = gnt_b ? OwnB : OwnA;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      rd_pend_d    = 1'b0;
      rd_owner_d   = rd_owner_q;
      if (gnt_a || gnt_b) begin
         if (gnt_owner == last_owner_q) begin
            burst_cnt_d = (burst_cnt_q >= BurstMax) ? BurstMax : burst_cnt_q + 4'd1;
         end else begin
            last_owner_d = gnt_owner;
            burst_cnt_d  = 4'd1;
         end
      end else begin
         burst_cnt_d = 4'd0;
      end
      if ((gnt_a && !a.we) || (gnt_b && !b.we)) begin
         rd_pend_d  = 1'b1;
         rd_owner_d = gnt_owner;
      end
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         last_owner_q <= OwnB;
         burst_cnt_q  <= 4'd0;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= OwnA;
      end else begin
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         rd_pend_q    <= rd_pend_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   // Read data passes straight through in its return cycle and is held afterwards.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         if (a_rvalid) a_rdata_q <= ram_out_data;
         if (b_rvalid) b_rdata_q <= ram_out_data;
      end
   end

   assign a_rvalid = rd_pend_q && (rd_owner_q == OwnA);
   assign b_rvalid = rd_pend_q && (rd_owner_q == OwnB);

   assign a.gnt    = gnt_a;
   assign b.gnt    = gnt_b;
   assign a.rvalid = a_rvalid;
   assign b.rvalid = b_rvalid;
   assign a.rdata  = a_rvalid ? ram_out_data : a_rdata_q;
   assign b.rdata  = b_rvalid ? ram_out_data : b_rdata_q;

   always_comb begin
      ram_write_en = 1'b0;
      ram_addr     = '0;
      ram_in_data  = '0;
      if (gnt_a) begin
         ram_write_en = a.we;
         ram_addr     = a.addr;
         ram_in_data  = a.wdata;
      end else if (gnt_b) begin
         ram_write_en = b.we;
         ram_addr     = b.addr;
         ram_in_data  = b.wdata;
      end
   end

   a_gnt_onehot: assert property (@(posedge clk) disable iff (!xrst) !(gnt_a && gnt_b));
   a_gnt_req:    assert property (@(posedge clk) disable iff (!xrst)
                                  (!gnt_a || a.req) && (!gnt_b || b.req));
   a_burst_max:  assert property (@(posedge clk) disable iff (!xrst) burst_cnt_q <= BurstMax);

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Directed bench for hack_ram_arbiter with a behavioural synchronous-read RAM.
module tb_hack_ram_arbiter;

   logic        clk;
   logic        xrst;
   logic        ram_write_en;
   logic [15:0] ram_addr;
   logic [15:0] ram_in_data;
   logic [15:0] ram_out_data;
   logic [15:0] mem [0:65535];

   int n_tests = 0;
   int n_fail  = 0;

   hack_ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) a_if ();
   hack_ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b_if ();

   hack_ram_arbiter #(
      .ADDR_W   (16),
      .DATA_W   (16),
      .MAX_BURST(4)
   ) dut (
      .clk         (clk),
      .xrst        (xrst),
      .a           (a_if),
      .b           (b_if),
      .ram_write_en(ram_write_en),
      .ram_addr    (ram_addr),
      .ram_in_data (ram_in_data),
      .ram_out_data(ram_out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (ram_write_en) mem[ram_addr] <= ram_in_data;
      ram_out_data <= mem[ram_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout required finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   // Drive both requesters just after a falling edge, then settle before checking.
   task automatic drive(input logic ar, input logic aw, input logic [15:0] aa,
                        input logic [15:0] ad, input logic br, input logic bw,
                        input logic [15:0] ba, input logic [15:0] bd);
      @(negedge clk);
      a_if.req = ar; a_if.we = aw; a_if.addr = aa; a_if.wdata = ad;
      b_if.req = br; b_if.we = bw; b_if.addr = ba; b_if.wdata = bd;
      #1;
   endtask

   bit exp_a [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

   initial begin
      xrst = 1'b0;
      a_if.req = 0; a_if.we = 0; a_if.addr = 0; a_if.wdata = 0;
      b_if.req = 0; b_if.we = 0; b_if.addr = 0; b_if.wdata = 0;
      #12;
      check_val("rst_a_rvalid", a_if.rvalid, 0);
      check_val("rst_b_rvalid", b_if.rvalid, 0);
      check_val("rst_a_rdata", a_if.rdata, 0);
      check_val("rst_b_rdata", b_if.rdata, 0);
      check_val("rst_ram_we", ram_write_en, 0);
      @(negedge clk);
      xrst = 1'b1;

      // A alone: write then read back
      drive(1, 1, 16'h0010, 16'h1234, 0, 0, 0, 0);
      check_val("t1_wr_gnt", a_if.gnt, 1);
      check_val("t1_wr_we", ram_write_en, 1);
      check_val("t1_wr_addr", ram_addr, 16'h0010);
      check_val("t1_wr_data", ram_in_data, 16'h1234);
      drive(1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0);
      check_val("t1_rd_gnt", a_if.gnt, 1);
      check_val("t1_rd_we", ram_write_en, 0);
      check_val("t1_wr_no_rvalid", a_if.rvalid, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check_val("t1_idle_gnt", a_if.gnt, 0);
      check_val("t1_idle_ram_addr", ram_addr, 0);
      check_val("t1_rvalid", a_if.rvalid, 1);
      check_val("t1_rdata", a_if.rdata, 16'h1234);
      check_val("t1_b_rvalid", b_if.rvalid, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check_val("t1_rvalid_drop", a_if.rvalid, 0);
      check_val("t1_rdata_hold", a_if.rdata, 16'h1234);

      // Load data, then alternating sole-requester reads
      drive(1, 1, 16'h0021, 16'h0055, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 1, 16'h0020, 16'h00AA);
      check_val("t5_b_wr_gnt", b_if.gnt, 1);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) drive(1, 0, 16'h0021, 0, 0, 0, 0, 0);
         else            drive(0, 0, 0, 0, 1, 0, 16'h0020, 0);
         check_val("t5_a_gnt", a_if.gnt, (i % 2 == 0));
         check_val("t5_b_gnt", b_if.gnt, (i % 2 == 1));
         if (i > 0) begin
            check_val("t5_a_rvalid", a_if.rvalid, (i % 2 == 1));
            check_val("t5_b_rvalid", b_if.rvalid, (i % 2 == 0));
            if (i % 2 == 1) check_val("t5_a_rdata", a_if.rdata, 16'h0055);
            else            check_val("t5_b_rdata", b_if.rdata, 16'h00AA);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check_val("t5_last_b_rvalid", b_if.rvalid, 1);
      check_val("t5_last_b_rdata", b_if.rdata, 16'h00AA);
      check_val("t5_last_a_rvalid", a_if.rvalid, 0);

      // Fresh reset, then continuous contention with reads from both
      xrst = 1'b0;
      #2;
      check_val("t2_rst_b_rdata", b_if.rdata, 0);
      for (int i = 0; i < 12; i++) begin
         drive(1, 0, 16'h0021, 0, 1, 0, 16'h0020, 0);
         if (i == 0) xrst = 1'b1;
         #1;
         check_val("t3_a_gnt", a_if.gnt, exp_a[i]);
         check_val("t3_b_gnt", b_if.gnt, !exp_a[i]);
         check_val("t3_burst_le4", dut.burst_cnt_q <= 4'd4, 1);
         if (i > 0) begin
            check_val("t3_a_rvalid", a_if.rvalid, exp_a[i-1]);
            check_val("t3_b_rvalid", b_if.rvalid, !exp_a[i-1]);
            if (exp_a[i-1]) check_val("t3_a_rdata", a_if.rdata, 16'h0055);
            else            check_val("t3_b_rdata", b_if.rdata, 16'h00AA);
         end
      end

      // Sole requester ignores the burst limit; contention then switches at once
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 16'h0021, 0, 0, 0, 0, 0);
         check_val("t4_a_sole_gnt", a_if.gnt, 1);
      end
      drive(1, 0, 16'h0021, 0, 1, 0, 16'h0020, 0);
      check_val("t4_b_gnt", b_if.gnt, 1);
      check_val("t4_a_gnt", a_if.gnt, 0);

      // Async reset between a read grant and its return
      drive(1, 0, 16'h0021, 0, 0, 0, 0, 0);
      check_val("t6_a_gnt", a_if.gnt, 1);
      @(posedge clk);
      #1;
      check_val("t6_rvalid_pre", a_if.rvalid, 1);
      xrst = 1'b0;
      #1;
      check_val("t6_rvalid_rst", a_if.rvalid, 0);
      check_val("t6_rdata_rst", a_if.rdata, 0);
      @(negedge clk);
      xrst = 1'b1;
      drive(1, 0, 16'h0021, 0, 1, 0, 16'h0020, 0);
      check_val("t6_a_first", a_if.gnt, 1);
      check_val("t6_b_first", b_if.gnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
